serial_add_ctrl: RTL and testbench

Bit-serial adder sequencer that time-multiplexes one external 1-bit full adder over WIDTH cycles to add two WIDTH-bit operands. It sits between a parallel request interface (start/op_a/op_b) and the full-adder cell's a/b/ci inputs and sum/co outputs. It holds the operand and result shift registers, the carry flip-flop, the bit counter and the start/done handshake.

---
 rtl/serial_add_ctrl.sv | 161 ++++++++++++++++
 tb/tb_serial_add_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer. Adds two WIDTH-bit operands over WIDTH
// cycles by driving one external 1-bit full-adder cell, LSB first.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, sub          request (sampled in IDLE only), subtract request
//   op_a, op_b          operands, sampled with start
//   busy, done          busy in RUN/DONE, done is a one-cycle pulse
//   result, cout        WIDTH-bit sum and carry out (held after done)
//   fa_a, fa_b, fa_ci   full-adder cell inputs (0 outside RUN)
//   fa_sum, fa_co       full-adder cell outputs (combinational from fa_*)
//
// Build option: define SERIAL_ADD_SUB_EN to enable subtraction (op_a + ~op_b + 1).
// Without it, sub is ignored and the block only adds.

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    input  logic             fa_sum,
    input  logic             fa_co
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_sa;
    logic [WIDTH-1:0]  r_sb;
    logic [WIDTH-1:0]  r_result;
    logic [CntW-1:0]   r_cnt;
    logic              r_carry;
    logic              r_cout;
    logic              w_last_bit;
    logic              w_sub_start;   // carry-in / invert value to latch at start
    logic              w_sub_q;       // subtract mode of the operation in flight

`ifdef SERIAL_ADD_SUB_EN
    logic              r_sub;

    assign w_sub_start = sub;
    assign w_sub_q     = r_sub;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sub <= 1'b0;
        end else if (r_state == StIdle && start) begin
            r_sub <= sub;
        end
    end
`else
    logic              w_sub_unused;

    assign w_sub_unused = sub;
    assign w_sub_start  = 1'b0;
    assign w_sub_q      = 1'b0;
`endif

    assign w_last_bit = (r_cnt == CntW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and outputs
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        fa_a         = 1'b0;
        fa_b         = 1'b0;
        fa_ci        = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                busy  = 1'b1;
                fa_a  = r_sa[0];
                fa_b  = r_sb[0] ^ w_sub_q;
                fa_ci = r_carry;
                if (w_last_bit) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Datapath: operand/result shift registers, carry flop, bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_sa    <= op_a;
                        r_sb    <= op_b;
                        r_carry <= w_sub_start;
                        r_cnt   <= '0;
                    end
                end
                StRun: begin
                    // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
                    r_result <= {fa_sum, r_result[WIDTH-1:1]};
                    r_carry  <= fa_co;
                    r_sa     <= r_sa >> 1;
                    r_sb     <= r_sb >> 1;
                    r_cnt    <= r_cnt + CntW'(1);
                    if (w_last_bit) begin
                        r_cout <= fa_co;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;
    assign cout   = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
`timescale 1ns/1ns
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         busy, done, cout, fa_a, fa_b, fa_ci, fa_sum, fa_co;
    logic [W-1:0] result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // External full-adder cell
    assign fa_sum = fa_a ^ fa_b ^ fa_ci;
    assign fa_co  = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .fa_a   (fa_a),
        .fa_b   (fa_b),
        .fa_ci  (fa_ci),
        .fa_sum (fa_sum),
        .fa_co  (fa_co)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic eff_sub(input logic s);
`ifdef SERIAL_ADD_SUB_EN
        return s;
`else
        return 1'b0 & s;
`endif
    endfunction

    function automatic logic [W:0] full_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
        logic [W-1:0] bb;
        bb = s ? ~b : b;
        return {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s};
    endfunction

    // Carry into bit k of a + b' + s, from plain arithmetic on the low k bits.
    function automatic logic carry_in(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic s, input int k);
        logic [63:0] mask, bb, tot;
        mask = (64'd1 << k) - 64'd1;
        bb   = {56'd0, (s ? ~b : b)};
        tot  = ({56'd0, a} & mask) + (bb & mask) + {63'd0, s};
        return tot[k];
    endfunction

    int           m_left = 0;     // cycles left busy for the current operation
    logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
    logic         m_sub = 1'b0, m_cout = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_res  <= '0;
            m_cout <= 1'b0;
            m_a    <= '0;
            m_b    <= '0;
            m_sub  <= 1'b0;
        end else if (m_left == 0) begin
            if (start) begin
                m_left <= W + 1;
                m_a    <= op_a;
                m_b    <= op_b;
                m_sub  <= eff_sub(sub);
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) begin
                {m_cout, m_res} <= full_sum(m_a, m_b, m_sub);
            end
        end
    end

    // Compare process: every cycle, sampled at the falling edge
    initial begin
        forever begin
            int k;
            @(negedge clk);
            check("busy", 64'(busy), 64'(m_left != 0));
            check("done", 64'(done), 64'(m_left == 1));
            if (m_left >= 2) begin
                k = W + 1 - m_left;
                check("fa_a", 64'(fa_a), 64'(m_a[k]));
                check("fa_b", 64'(fa_b), 64'(m_b[k] ^ m_sub));
                check("fa_ci", 64'(fa_ci), 64'(carry_in(m_a, m_b, m_sub, k)));
            end else begin
                check("fa_idle", {61'd0, fa_a, fa_b, fa_ci}, 64'd0);
                check("result", 64'(result), 64'(m_res));
                check("cout", 64'(cout), 64'(m_cout));
            end
        end
    end

    // ---------------- directed operations ----------------
    // Called just after a falling edge while idle; start is sampled at the next rising edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] r, output logic c, output int done_cyc,
                         output int n_done, output logic [12:0] busy_mask,
                         output logic [W-1:0] ci_seq);
        r = '0; c = 1'b0; done_cyc = -1; n_done = 0; busy_mask = '0; ci_seq = '0;
        op_a = a; op_b = b; sub = s; start = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            busy_mask[cyc] = busy;
            if (cyc <= W) ci_seq[cyc-1] = fa_ci;
            if (done) begin
                n_done++;
                done_cyc = cyc;
                r = result;
                c = cout;
            end
        end
    endtask

    logic [W-1:0] r, ci_seq;
    logic         c;
    int           dcyc, ndone;
    logic [12:0]  bmask;

    initial begin
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_op(8'h0F, 8'h01, 1'b0, r, c, dcyc, ndone, bmask, ci_seq);
        check("t1_result", 64'(r), 64'h10);
        check("t1_cout", 64'(c), 64'd0);
        check("t1_done_cycle", 64'(dcyc), 64'd9);
        check("t1_busy_cycles", 64'(bmask), 64'h03FE);

        do_op(8'hFF, 8'h01, 1'b0, r, c, dcyc, ndone, bmask, ci_seq);
        check("t2_result", 64'(r), 64'h00);
        check("t2_cout", 64'(c), 64'd1);
        check("t2_fa_ci_seq", 64'(ci_seq), 64'hFE);

`ifdef SERIAL_ADD_SUB_EN
        do_op(8'h05, 8'h07, 1'b1, r, c, dcyc, ndone, bmask, ci_seq);
        check("sub_5_7_result", 64'(r), 64'hFE);
        check("sub_5_7_cout", 64'(c), 64'd0);
        do_op(8'h07, 8'h05, 1'b1, r, c, dcyc, ndone, bmask, ci_seq);
        check("sub_7_5_result", 64'(r), 64'h02);
        check("sub_7_5_cout", 64'(c), 64'd1);
`else
        do_op(8'h05, 8'h07, 1'b1, r, c, dcyc, ndone, bmask, ci_seq);
        check("nosub_result", 64'(r), 64'h0C);
        check("nosub_cout", 64'(c), 64'd0);
`endif

        // Starts during RUN and DONE are ignored
        op_a = 8'h11; op_b = 8'h22; sub = 1'b0; start = 1'b1;
        ndone = 0; dcyc = -1; r = '0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                dcyc = cyc;
                r = result;
            end
            start = (cyc == 3 || cyc == 9);
            if (start) begin
                op_a = 8'hFF;
                op_b = 8'hFF;
            end
        end
        check("ovl_done_count", 64'(ndone), 64'd1);
        check("ovl_done_cycle", 64'(dcyc), 64'd9);
        check("ovl_result", 64'(r), 64'h33);
        check("ovl_hold", 64'(result), 64'h33);

        // Reset in cycle 4 of RUN
        op_a = 8'h11; op_b = 8'h22; start = 1'b1;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("rst_outputs", {54'd0, busy, done, cout, fa_a, fa_b, fa_ci, 2'b0} |
                 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("rst_no_done", 64'(ndone), 64'd0);
        do_op(8'h80, 8'h80, 1'b0, r, c, dcyc, ndone, bmask, ci_seq);
        check("post_rst_result", 64'(r), 64'h00);
        check("post_rst_cout", 64'(c), 64'd1);

        // Randomized traffic, including occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(2) == 0);
            sub   = 1'($urandom);
            case ($urandom_range(5))
                0: begin op_a = '1; op_b = '1; end
                1: begin op_a = '0; op_b = 8'($urandom); end
                default: begin op_a = 8'($urandom); op_b = 8'($urandom); end
            endcase
            rst = ($urandom_range(250) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (W + 3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
